// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one combinational ALU between EX issue (port 0) and an auxiliary unit (port 1)
//
// Port 0 has priority. Port 1 is guaranteed a grant after at most STARVE_MAX consecutive
// port-0 grants while it waits. Granted ops flow through two register stages:
//   S1 holds the issued op and drives alu_*.
//   S2 captures alu_res and drives the tagged response channel.
//
// Ports
//   clk, rst_n                     clock (rising edge), asynchronous active-low reset
//   r0_valid/r0_ready/r0_ctr/a/b   port 0 request channel (pipeline EX issue)
//   r1_valid/r1_ready/r1_ctr/a/b   port 1 request channel (auxiliary unit)
//   flush                          kills all port-0 work in S1/S2 and blocks port-0 grants
//   alu_ctr, alu_a, alu_b          ALU inputs, forced to 0 while S1 is empty
//   alu_res                        ALU result, combinational from alu_*
//   rsp_valid/rsp_ready            response handshake
//   rsp_id, rsp_data               response source (0 = port 0, 1 = port 1) and result
//   err_ctr                        one-cycle pulse after an illegal op code is granted
//
// Build option
//   ALU_ARB_CTR_CHECK_EN  when defined, illegal op codes are replaced by add in S1 and
//                         err_ctr pulses; otherwise codes pass through and err_ctr is 0.
module alu_share_arb #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            r0_valid,
  output logic            r0_ready,
  input  logic [3:0]      r0_ctr,
  input  logic [XLEN-1:0] r0_a,
  input  logic [XLEN-1:0] r0_b,
  input  logic            r1_valid,
  output logic            r1_ready,
  input  logic [3:0]      r1_ctr,
  input  logic [XLEN-1:0] r1_a,
  input  logic [XLEN-1:0] r1_b,
  input  logic            flush,
  output logic [3:0]      alu_ctr,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_res,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [XLEN-1:0] rsp_data,
  output logic            err_ctr
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);
  logic [CW-1:0]   starve_cnt, starve_n;
  logic            s1_v, s1_id;
  logic [3:0]      s1_ctr, s1_ctr_in;
  logic [XLEN-1:0] s1_a, s1_b;
  logic            s2_v, s2_id;
  logic [XLEN-1:0] s2_data;
  logic            s2_free, s1_adv, s1_acc, starved, g0, g1, grant;
  logic            s1_kill, s2_kill;
  logic [3:0]      g_ctr;
  logic [XLEN-1:0] g_a, g_b;
  // A flush kills id-0 entries; a killed S2 entry is hidden from the consumer immediately.
  assign s1_kill   = flush & ~s1_id;
  assign s2_kill   = flush & ~s2_id;
  assign rsp_valid = s2_v & ~s2_kill;
  assign rsp_id    = s2_id;
  assign rsp_data  = s2_data;
  assign s2_free   = ~s2_v | (rsp_valid & rsp_ready);
  assign s1_adv    = s1_v & s2_free;
  assign s1_acc    = ~s1_v | s1_adv;
  assign starved   = r1_valid && (starve_cnt == SMAX);
  assign g0        = s1_acc & ~flush & r0_valid & ~starved;
  assign g1        = s1_acc & r1_valid & ~g0;
  assign grant     = g0 | g1;
  assign r0_ready  = g0;
  assign r1_ready  = g1;
  assign g_ctr     = g1 ? r1_ctr : r0_ctr;
  assign g_a       = g1 ? r1_a : r0_a;
  assign g_b       = g1 ? r1_b : r0_b;
  assign alu_ctr   = s1_v ? s1_ctr : 4'b0000;
  assign alu_a     = s1_v ? s1_a : '0;
  assign alu_b     = s1_v ? s1_b : '0;
  // The count only builds while port 1 is actually waiting.
  always_comb begin
    starve_n = (!r1_valid || g1) ? '0 : (g0 && starve_cnt != SMAX) ? starve_cnt + 1'b1 : starve_cnt;
  end
`ifdef ALU_ARB_CTR_CHECK_EN
  logic err_q;
  function automatic logic ctr_ok(input logic [3:0] c);
    return c inside {4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
                     4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111};
  endfunction
  assign s1_ctr_in = ctr_ok(g_ctr) ? g_ctr : 4'b0000;
  assign err_ctr   = err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else err_q <= grant & ~ctr_ok(g_ctr);
  end
`else
  assign s1_ctr_in = g_ctr;
  assign err_ctr   = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      s1_v       <= 1'b0;
      s1_id      <= 1'b0;
      s1_ctr     <= 4'b0000;
      s1_a       <= '0;
      s1_b       <= '0;
      s2_v       <= 1'b0;
      s2_id      <= 1'b0;
      s2_data    <= '0;
    end else begin
      starve_cnt <= starve_n;
      s1_v       <= grant | (s1_v & ~s1_adv & ~s1_kill);
      if (grant) begin
        s1_id  <= g1;
        s1_ctr <= s1_ctr_in;
        s1_a   <= g_a;
        s1_b   <= g_b;
      end
      // A killed S1 entry may still move into S2, but it lands invalid.
      s2_v <= s1_adv ? ~s1_kill : (s2_v & ~s2_free & ~s2_kill);
      if (s1_adv) begin
        s2_id   <= s1_id;
        s2_data <= alu_res;
      end
    end
  end
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed self-checking bench for alu_share_arb
module tb_alu_share_arb;
  logic        clk = 1'b0;
  logic        rst_n, r0_valid, r0_ready, r1_valid, r1_ready, flush;
  logic        rsp_valid, rsp_ready, rsp_id, err_ctr;
  logic [3:0]  r0_ctr, r1_ctr, alu_ctr;
  logic [31:0] r0_a, r0_b, r1_a, r1_b, alu_a, alu_b, alu_res, rsp_data;
  int checks = 0;
  int errors = 0;
`ifdef ALU_ARB_CTR_CHECK_EN
  localparam logic [31:0] ILL_ERR = 1, ILL_CTR = 0, ILL_DATA = 5;
`else
  localparam logic [31:0] ILL_ERR = 0, ILL_CTR = 9, ILL_DATA = 0;
`endif
  always #5 clk = ~clk;
  function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0001: return a << b[4:0];
      4'b0010: return {31'b0, $signed(a) < $signed(b)};
      4'b0011: return {31'b0, a < b};
      4'b0100: return a ^ b;
      4'b0101: return a >> b[4:0];
      4'b1101: return $signed(a) >>> b[4:0];
      4'b0110: return a | b;
      4'b0111: return a & b;
      default: return 32'b0;
    endcase
  endfunction
  assign alu_res = alu_f(alu_ctr, alu_a, alu_b);
  alu_share_arb #(.XLEN(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_ctr(r0_ctr), .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_ctr(r1_ctr), .r1_a(r1_a), .r1_b(r1_b),
    .flush(flush), .alu_ctr(alu_ctr), .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .err_ctr(err_ctr)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic smp;
    @(negedge clk);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b0;
    r0_ctr = 4'd0; r0_a = 0; r0_b = 0; r1_ctr = 4'd0; r1_a = 0; r1_b = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    smp;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_alu_ctr", 32'(alu_ctr), 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_err", 32'(err_ctr), 0);
    // back-to-back add 5+7, sub 9-3
    cyc; rsp_ready = 1'b1; r0_valid = 1'b1; r0_ctr = 4'b0000; r0_a = 5; r0_b = 7;
    smp; chk("b2b_grant0", 32'(r0_ready), 1);
    cyc; r0_ctr = 4'b1000; r0_a = 9; r0_b = 3;
    smp; chk("b2b_grant1", 32'(r0_ready), 1); chk("b2b_alu_a", alu_a, 5); chk("b2b_alu_ctr0", 32'(alu_ctr), 0);
    cyc; r0_valid = 1'b0;
    smp; chk("b2b_v0", 32'(rsp_valid), 1); chk("b2b_d0", rsp_data, 12); chk("b2b_id0", 32'(rsp_id), 0);
    chk("b2b_alu_ctr1", 32'(alu_ctr), 8);
    cyc;
    smp; chk("b2b_v1", 32'(rsp_valid), 1); chk("b2b_d1", rsp_data, 6);
    cyc;
    smp; chk("b2b_idle", 32'(rsp_valid), 0); chk("b2b_quiet", alu_a, 0);
    // starvation: pattern 0,0,0,0,1 repeating
    for (int i = 0; i < 10; i++) begin
      cyc;
      if (i == 0) begin
        r0_valid = 1'b1; r0_ctr = 4'b0000; r0_a = 1; r0_b = 1;
        r1_valid = 1'b1; r1_ctr = 4'b0100; r1_a = 3; r1_b = 5;
      end
      smp;
      chk($sformatf("starve_r1_%0d", i), 32'(r1_ready), (i % 5 == 4) ? 1 : 0);
      chk($sformatf("starve_r0_%0d", i), 32'(r0_ready), (i % 5 == 4) ? 0 : 1);
      if (i == 6) begin
        chk("starve_rsp_id", 32'(rsp_id), 1);
        chk("starve_rsp_data", rsp_data, 6);
      end
    end
    cyc; r0_valid = 1'b0; r1_valid = 1'b0;
    smp;
    repeat (2) begin cyc; smp; end
    chk("starve_drained", 32'(rsp_valid), 0);
    // backpressure: 3 ops, rsp_ready low for 5 cycles
    cyc; rsp_ready = 1'b0; r0_valid = 1'b1; r0_ctr = 4'b0000; r0_a = 1; r0_b = 2;
    smp; chk("bp_gA", 32'(r0_ready), 1);
    cyc; r0_ctr = 4'b0110; r0_a = 4; r0_b = 8;
    smp; chk("bp_gB", 32'(r0_ready), 1);
    cyc; r0_ctr = 4'b0001; r0_a = 1; r0_b = 4;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) cyc;
      smp;
      chk($sformatf("bp_stall_%0d", i), 32'(r0_ready), 0);
      chk($sformatf("bp_hold_v_%0d", i), 32'(rsp_valid), 1);
      chk($sformatf("bp_hold_d_%0d", i), rsp_data, 3);
    end
    cyc; rsp_ready = 1'b1;
    smp; chk("bp_gC", 32'(r0_ready), 1); chk("bp_d0", rsp_data, 3);
    cyc; r0_valid = 1'b0;
    smp; chk("bp_v1", 32'(rsp_valid), 1); chk("bp_d1", rsp_data, 12);
    cyc;
    smp; chk("bp_v2", 32'(rsp_valid), 1); chk("bp_d2", rsp_data, 16);
    cyc;
    smp; chk("bp_done", 32'(rsp_valid), 0);
    // flush with S1 = id0, S2 = id1
    cyc; rsp_ready = 1'b0; r1_valid = 1'b1; r1_ctr = 4'b0111; r1_a = 32'hF0; r1_b = 32'h3C;
    smp; chk("fl_g1", 32'(r1_ready), 1);
    cyc; r1_valid = 1'b0; r0_valid = 1'b1; r0_ctr = 4'b0000; r0_a = 10; r0_b = 20;
    smp; chk("fl_g0", 32'(r0_ready), 1);
    cyc; r0_a = 99; r0_b = 1; flush = 1'b1; rsp_ready = 1'b1;
    smp; chk("fl_block", 32'(r0_ready), 0); chk("fl_v", 32'(rsp_valid), 1);
    chk("fl_id", 32'(rsp_id), 1); chk("fl_d", rsp_data, 32'h30);
    cyc; flush = 1'b0; r0_valid = 1'b0;
    smp; chk("fl_gone0", 32'(rsp_valid), 0); chk("fl_quiet", alu_a, 0);
    cyc;
    smp; chk("fl_gone1", 32'(rsp_valid), 0);
    // flush masks an id-0 response held in S2
    cyc; rsp_ready = 1'b0; r0_valid = 1'b1; r0_ctr = 4'b0000; r0_a = 1; r0_b = 1;
    smp;
    cyc; r0_valid = 1'b0;
    smp;
    cyc;
    smp; chk("fm_v", 32'(rsp_valid), 1); chk("fm_d", rsp_data, 2);
    cyc; flush = 1'b1;
    smp; chk("fm_mask", 32'(rsp_valid), 0);
    cyc; flush = 1'b0;
    smp; chk("fm_gone", 32'(rsp_valid), 0);
    // illegal op code 1001 on port 1
    cyc; rsp_ready = 1'b1; r1_valid = 1'b1; r1_ctr = 4'b1001; r1_a = 2; r1_b = 3;
    smp; chk("ill_g1", 32'(r1_ready), 1); chk("ill_err0", 32'(err_ctr), 0);
    cyc; r1_valid = 1'b0;
    smp; chk("ill_err1", 32'(err_ctr), ILL_ERR); chk("ill_ctr", 32'(alu_ctr), ILL_CTR);
    cyc;
    smp; chk("ill_err2", 32'(err_ctr), 0); chk("ill_v", 32'(rsp_valid), 1);
    chk("ill_id", 32'(rsp_id), 1); chk("ill_d", rsp_data, ILL_DATA);
    // asynchronous reset with S1 and S2 full
    cyc; rsp_ready = 1'b0; r0_valid = 1'b1; r0_ctr = 4'b0000; r0_a = 4; r0_b = 4;
    smp;
    cyc; r0_a = 6;
    smp;
    cyc; r0_valid = 1'b0;
    smp; chk("mr_full_v", 32'(rsp_valid), 1); chk("mr_full_a", alu_a, 6);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_v", 32'(rsp_valid), 0); chk("mr_d", rsp_data, 0); chk("mr_id", 32'(rsp_id), 0);
    chk("mr_alu_a", alu_a, 0); chk("mr_alu_ctr", 32'(alu_ctr), 0); chk("mr_err", 32'(err_ctr), 0);
    cyc; cyc; rst_n = 1'b1; rsp_ready = 1'b1;
    smp; chk("mr_after0", 32'(rsp_valid), 0);
    repeat (2) begin cyc; smp; end
    chk("mr_after1", 32'(rsp_valid), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
